// File: rtl/dx_stage_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dx_stage_control_pkg                                                     |
// | ISA constants, register-tag types and FSM encodings for D->X control.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dx_stage_control_pkg;

    localparam int          TAG_W        = 6;
    localparam logic [31:0] C_NOP        = 32'h0000_0000;

    localparam logic [4:0]  C_OP_RTYPE   = 5'b00000;
    localparam logic [4:0]  C_OP_BNE     = 5'b00010;
    localparam logic [4:0]  C_OP_JAL     = 5'b00011;
    localparam logic [4:0]  C_OP_JR      = 5'b00100;
    localparam logic [4:0]  C_OP_ADDI    = 5'b00101;
    localparam logic [4:0]  C_OP_BLT     = 5'b00110;
    localparam logic [4:0]  C_OP_SW      = 5'b00111;
    localparam logic [4:0]  C_OP_LW      = 5'b01000;
    localparam logic [4:0]  C_OP_SETX    = 5'b10101;
    localparam logic [4:0]  C_OP_BEX     = 5'b10110;

    localparam logic [4:0]  C_ALU_MUL    = 5'b00110;
    localparam logic [4:0]  C_ALU_DIV    = 5'b00111;

    localparam logic [4:0]  C_REG_RA     = 5'd31;
    localparam logic [4:0]  C_REG_STATUS = 5'd30;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t src_a;
        tag_t src_b;
        tag_t dst;
    } tags_t;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        X_LOAD   = 2'd0,
        X_HOLD   = 2'd1,
        X_BUBBLE = 2'd2
    } xsel_t;

    // Register index 0 maps to tag 0, which is the "no register" value.
    function automatic tag_t reg_tag(input logic [4:0] idx);
        return tag_t'({1'b0, idx});
    endfunction

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[31:27] == C_OP_RTYPE) &&
               ((insn[6:2] == C_ALU_MUL) || (insn[6:2] == C_ALU_DIV));
    endfunction

    function automatic logic reads_tag(input tags_t t, input tag_t tag);
        return (tag != '0) && ((t.src_a == tag) || (t.src_b == tag));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dx_stage_control_insn_reg_tags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | insn_reg_tags                                                            |
// | Combinational decode of an instruction into source/destination tags.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module insn_reg_tags
    import dx_stage_control_pkg::*;
(
    input  logic [31:12] i_insn,
    output tags_t        o_tags
);

    logic [4:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;

    assign w_op = i_insn[31:27];
    assign w_rd = i_insn[26:22];
    assign w_rs = i_insn[21:17];
    assign w_rt = i_insn[16:12];

    always_comb begin
        o_tags = '0;
        case (w_op)
            C_OP_RTYPE: begin
                o_tags.src_a = reg_tag(w_rs);
                o_tags.src_b = reg_tag(w_rt);
                o_tags.dst   = reg_tag(w_rd);
            end
            C_OP_ADDI, C_OP_LW: begin
                o_tags.src_a = reg_tag(w_rs);
                o_tags.dst   = reg_tag(w_rd);
            end
            // Stores and branches read the rd field as a source operand.
            C_OP_SW: begin
                o_tags.src_a = reg_tag(w_rs);
                o_tags.src_b = reg_tag(w_rd);
            end
            C_OP_BNE, C_OP_BLT: begin
                o_tags.src_a = reg_tag(w_rd);
                o_tags.src_b = reg_tag(w_rs);
            end
            C_OP_JR:   o_tags.src_a = reg_tag(w_rd);
            C_OP_JAL:  o_tags.dst   = reg_tag(C_REG_RA);
            C_OP_SETX: o_tags.dst   = reg_tag(C_REG_STATUS);
            C_OP_BEX:  o_tags.src_a = reg_tag(C_REG_STATUS);
            default:   o_tags = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dx_stage_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dx_stage_control                                                         |
// | D->X pipeline register with load-use, multdiv-wait and flush control.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dx_stage_control
    import dx_stage_control_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_insn_d,
    input  logic [31:0]      i_pc_d,
    input  logic             i_valid_d,
    input  logic             i_flush_x,
    input  logic             i_md_ready,
    output logic [31:0]      o_insn_x,
    output logic [31:0]      o_pc_x,
    output logic             o_valid_x,
    output logic [TAG_W-1:0] o_rs_x,
    output logic [TAG_W-1:0] o_rt_x,
    output logic [TAG_W-1:0] o_rd_x,
    output logic             o_stall_fd,
    output logic             o_md_start
);

    state_t      r_state;
    logic [31:0] r_insn_x;
    logic [31:0] r_pc_x;
    logic        r_valid_x;
    tags_t       r_tags;
    logic        r_md_start;

    state_t      w_state_next;
    xsel_t       w_sel;
    logic        w_stall_fd;
    logic        w_md_start_next;
    logic        w_load_use;
    tags_t       w_d_tags;
    tags_t       w_x_in_tags;
    tags_t       w_x_next_tags;
    logic [31:0] w_x_in_insn;
    logic [31:0] w_x_in_pc;
    logic        w_x_in_valid;

    insn_reg_tags u_tags_d (
        .i_insn (i_insn_d[31:12]),
        .o_tags (w_d_tags)
    );

    assign w_load_use = r_valid_x && (r_insn_x[31:27] == C_OP_LW) &&
                        (r_tags.dst != '0) && i_valid_d &&
                        reads_tag(w_d_tags, r_tags.dst);

    // Priority: reset > flush > multdiv wait > load-use > normal advance.
    always_comb begin
        w_state_next    = r_state;
        w_sel           = X_LOAD;
        w_stall_fd      = 1'b0;
        w_md_start_next = 1'b0;
        if (i_reset) begin
            w_state_next = ST_RUN;
            w_sel        = X_BUBBLE;
        end else if (i_flush_x) begin
            w_state_next = ST_RUN;
            w_sel        = X_BUBBLE;
        end else if (r_state == ST_MD_WAIT) begin
            if (i_md_ready) begin
                w_state_next = ST_RUN;
                w_sel        = X_LOAD;
            end else begin
                w_sel        = X_HOLD;
                w_stall_fd   = 1'b1;
            end
        end else if (w_load_use) begin
            w_sel      = X_BUBBLE;
            w_stall_fd = 1'b1;
        end
        if (!i_reset && (w_sel == X_LOAD) && i_valid_d && is_muldiv(i_insn_d)) begin
            w_state_next    = ST_MD_WAIT;
            w_md_start_next = 1'b1;
        end
    end

    always_comb begin
        w_x_in_insn  = C_NOP;
        w_x_in_pc    = '0;
        w_x_in_valid = 1'b0;
        case (w_sel)
            X_LOAD: begin
                w_x_in_insn  = i_insn_d;
                w_x_in_pc    = i_pc_d;
                w_x_in_valid = i_valid_d;
            end
            X_HOLD: begin
                w_x_in_insn  = r_insn_x;
                w_x_in_pc    = r_pc_x;
                w_x_in_valid = r_valid_x;
            end
            default: begin
                w_x_in_insn  = C_NOP;
                w_x_in_pc    = '0;
                w_x_in_valid = 1'b0;
            end
        endcase
    end

    insn_reg_tags u_tags_x (
        .i_insn (w_x_in_insn[31:12]),
        .o_tags (w_x_in_tags)
    );

    assign w_x_next_tags = w_x_in_valid ? w_x_in_tags : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_insn_x   <= C_NOP;
            r_pc_x     <= '0;
            r_valid_x  <= 1'b0;
            r_tags     <= '0;
            r_md_start <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_insn_x   <= w_x_in_insn;
            r_pc_x     <= w_x_in_pc;
            r_valid_x  <= w_x_in_valid;
            r_tags     <= w_x_next_tags;
            r_md_start <= w_md_start_next;
        end
    end

    assign o_insn_x   = r_insn_x;
    assign o_pc_x     = r_pc_x;
    assign o_valid_x  = r_valid_x;
    assign o_rs_x     = r_tags.src_a;
    assign o_rt_x     = r_tags.src_b;
    assign o_rd_x     = r_tags.dst;
    assign o_stall_fd = w_stall_fd;
    assign o_md_start = r_md_start;

endmodule
`default_nettype wire
